// File: rtl/axi4_lite_master_arb.sv
// AXI4-Lite master with round-robin read/write arbitration, a one-deep pending
// slot for the losing request, independent AW/W handshakes and a watchdog.
module axi4_lite_master_arb #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     waddr_i,
  input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_i,
  input  logic                          start_write_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     raddr_i,
  input  logic                          start_read_i,
  output logic                          ready_o,
  output logic [AXI_DATA_WIDTH-1:0]     data_o,
  output logic [1:0]                    resp_o,
  output logic                          write_fault_o,
  output logic                          read_fault_o,
  output logic                          timeout_o,
  output logic                          done_o,
  input  logic                          AW_READY,
  output logic                          AW_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
  output logic [2:0]                    AW_PROT,
  input  logic                          W_READY,
  output logic                          W_VALID,
  output logic [AXI_DATA_WIDTH-1:0]     W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
  input  logic [1:0]                    B_RESP,
  input  logic                          B_VALID,
  output logic                          B_READY,
  input  logic                          AR_READY,
  output logic                          AR_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]     AR_ADDR,
  output logic [2:0]                    AR_PROT,
  input  logic [AXI_DATA_WIDTH-1:0]     R_DATA,
  input  logic [1:0]                    R_RESP,
  input  logic                          R_VALID,
  output logic                          R_READY
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned WD_WIDTH   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_AW_W, ST_WR_B, ST_RD_AR, ST_RD_R, ST_DONE
  } state_e;

  typedef enum logic {RR_READ, RR_WRITE} rr_e;

  state_e                      state_q, state_d;
  rr_e                         rr_last_q, rr_last_d;
  logic                        ready_q, ready_d;
  logic                        aw_valid_q, aw_valid_d;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic                        w_valid_q, w_valid_d;
  logic [AXI_DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0]       w_strb_q, w_strb_d;
  logic                        b_ready_q, b_ready_d;
  logic                        ar_valid_q, ar_valid_d;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
  logic                        r_ready_q, r_ready_d;
  logic [AXI_DATA_WIDTH-1:0]   data_q, data_d;
  logic [1:0]                  resp_q, resp_d;
  logic                        write_fault_q, write_fault_d;
  logic                        read_fault_q, read_fault_d;
  logic                        timeout_q, timeout_d;
  logic                        done_q, done_d;
  logic                        pend_valid_q, pend_valid_d;
  logic                        pend_write_q, pend_write_d;
  logic [AXI_ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
  logic [AXI_DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic [STRB_WIDTH-1:0]       pend_strb_q, pend_strb_d;
  logic [WD_WIDTH-1:0]         wd_q, wd_d;

  logic expire;
  logic launch_wr;
  logic launch_rd;
  logic from_pend;
  logic abort;

  assign expire = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LIMIT);

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    ready_d       = ready_q;
    aw_valid_d    = aw_valid_q;
    aw_addr_d     = aw_addr_q;
    w_valid_d     = w_valid_q;
    w_data_d      = w_data_q;
    w_strb_d      = w_strb_q;
    b_ready_d     = b_ready_q;
    ar_valid_d    = ar_valid_q;
    ar_addr_d     = ar_addr_q;
    r_ready_d     = r_ready_q;
    data_d        = data_q;
    resp_d        = resp_q;
    pend_valid_d  = pend_valid_q;
    pend_write_d  = pend_write_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    pend_strb_d   = pend_strb_q;
    write_fault_d = 1'b0;
    read_fault_d  = 1'b0;
    timeout_d     = 1'b0;
    done_d        = 1'b0;
    wd_d          = wd_q + 1'b1;
    launch_wr     = 1'b0;
    launch_rd     = 1'b0;
    from_pend     = 1'b0;
    abort         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (start_write_i && start_read_i) begin
          launch_wr    = (rr_last_q == RR_READ);
          launch_rd    = !launch_wr;
          pend_valid_d = 1'b1;
          pend_write_d = launch_rd;
          pend_addr_d  = launch_wr ? raddr_i : waddr_i;
          pend_data_d  = wdata_i;
          pend_strb_d  = wstrb_i;
        end else begin
          launch_wr = start_write_i;
          launch_rd = start_read_i;
        end
        if (launch_wr) rr_last_d = RR_WRITE;
        else if (launch_rd) rr_last_d = RR_READ;
      end
      ST_WR_AW_W: begin
        aw_valid_d = aw_valid_q && !AW_READY;
        w_valid_d  = w_valid_q && !W_READY;
        if (expire) begin
          abort = 1'b1;
        end else if (!aw_valid_d && !w_valid_d) begin
          state_d   = ST_WR_B;
          b_ready_d = 1'b1;
        end
      end
      // A response on the expiry cycle wins over the watchdog.
      ST_WR_B: begin
        if (B_VALID) begin
          state_d       = ST_DONE;
          b_ready_d     = 1'b0;
          resp_d        = B_RESP;
          write_fault_d = (B_RESP != 2'b00);
          done_d        = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_RD_AR: begin
        if (expire) begin
          abort = 1'b1;
        end else if (AR_READY) begin
          state_d    = ST_RD_R;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      ST_RD_R: begin
        if (R_VALID) begin
          state_d      = ST_DONE;
          r_ready_d    = 1'b0;
          data_d       = R_DATA;
          resp_d       = R_RESP;
          read_fault_d = (R_RESP != 2'b00);
          done_d       = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_DONE: begin
        wd_d = '0;
        if (pend_valid_q) begin
          from_pend    = 1'b1;
          launch_wr    = pend_write_q;
          launch_rd    = !pend_write_q;
          pend_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d       = ST_DONE;
      aw_valid_d    = 1'b0;
      w_valid_d     = 1'b0;
      b_ready_d     = 1'b0;
      ar_valid_d    = 1'b0;
      r_ready_d     = 1'b0;
      resp_d        = 2'b10;
      timeout_d     = 1'b1;
      done_d        = 1'b1;
      write_fault_d = (state_q == ST_WR_AW_W) || (state_q == ST_WR_B);
      read_fault_d  = (state_q == ST_RD_AR) || (state_q == ST_RD_R);
    end

    if (launch_wr) begin
      state_d    = ST_WR_AW_W;
      ready_d    = 1'b0;
      wd_d       = '0;
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
      aw_addr_d  = from_pend ? pend_addr_q : waddr_i;
      w_data_d   = from_pend ? pend_data_q : wdata_i;
      w_strb_d   = from_pend ? pend_strb_q : wstrb_i;
    end

    if (launch_rd) begin
      state_d    = ST_RD_AR;
      ready_d    = 1'b0;
      wd_d       = '0;
      ar_valid_d = 1'b1;
      ar_addr_d  = from_pend ? pend_addr_q : raddr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      rr_last_q     <= RR_READ;
      ready_q       <= 1'b1;
      aw_valid_q    <= 1'b0;
      aw_addr_q     <= '0;
      w_valid_q     <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      b_ready_q     <= 1'b0;
      ar_valid_q    <= 1'b0;
      ar_addr_q     <= '0;
      r_ready_q     <= 1'b0;
      data_q        <= '0;
      resp_q        <= '0;
      write_fault_q <= 1'b0;
      read_fault_q  <= 1'b0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_write_q  <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      pend_strb_q   <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      ready_q       <= ready_d;
      aw_valid_q    <= aw_valid_d;
      aw_addr_q     <= aw_addr_d;
      w_valid_q     <= w_valid_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      b_ready_q     <= b_ready_d;
      ar_valid_q    <= ar_valid_d;
      ar_addr_q     <= ar_addr_d;
      r_ready_q     <= r_ready_d;
      data_q        <= data_d;
      resp_q        <= resp_d;
      write_fault_q <= write_fault_d;
      read_fault_q  <= read_fault_d;
      timeout_q     <= timeout_d;
      done_q        <= done_d;
      pend_valid_q  <= pend_valid_d;
      pend_write_q  <= pend_write_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      pend_strb_q   <= pend_strb_d;
      wd_q          <= wd_d;
    end
  end

  assign ready_o       = ready_q;
  assign data_o        = data_q;
  assign resp_o        = resp_q;
  assign write_fault_o = write_fault_q;
  assign read_fault_o  = read_fault_q;
  assign timeout_o     = timeout_q;
  assign done_o        = done_q;
  assign AW_VALID      = aw_valid_q;
  assign AW_ADDR       = aw_addr_q;
  assign AW_PROT       = 3'b000;
  assign W_VALID       = w_valid_q;
  assign W_DATA        = w_data_q;
  assign W_STRB        = w_strb_q;
  assign B_READY       = b_ready_q;
  assign AR_VALID      = ar_valid_q;
  assign AR_ADDR       = ar_addr_q;
  assign AR_PROT       = 3'b000;
  assign R_READY       = r_ready_q;

endmodule

// File: tb/tb_axi4_lite_master_arb.sv
// Directed bench for axi4_lite_master_arb: handshakes, arbitration order,
// pending launch, watchdog abort, response-vs-expiry priority, mid-flight reset.
module tb_axi4_lite_master_arb;

  localparam int unsigned AW_W = 64;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;

  logic            clk_i;
  logic            rstn_i;
  logic [AW_W-1:0] waddr_i;
  logic [DW-1:0]   wdata_i;
  logic [SW-1:0]   wstrb_i;
  logic            start_write_i;
  logic [AW_W-1:0] raddr_i;
  logic            start_read_i;
  logic            ready_o;
  logic [DW-1:0]   data_o;
  logic [1:0]      resp_o;
  logic            write_fault_o, read_fault_o, timeout_o, done_o;
  logic            AW_READY, AW_VALID;
  logic [AW_W-1:0] AW_ADDR;
  logic [2:0]      AW_PROT;
  logic            W_READY, W_VALID;
  logic [DW-1:0]   W_DATA;
  logic [SW-1:0]   W_STRB;
  logic [1:0]      B_RESP;
  logic            B_VALID, B_READY;
  logic            AR_READY, AR_VALID;
  logic [AW_W-1:0] AR_ADDR;
  logic [2:0]      AR_PROT;
  logic [DW-1:0]   R_DATA;
  logic [1:0]      R_RESP;
  logic            R_VALID, R_READY;

  axi4_lite_master_arb #(
    .AXI_ADDR_WIDTH (AW_W),
    .AXI_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .waddr_i       (waddr_i),
    .wdata_i       (wdata_i),
    .wstrb_i       (wstrb_i),
    .start_write_i (start_write_i),
    .raddr_i       (raddr_i),
    .start_read_i  (start_read_i),
    .ready_o       (ready_o),
    .data_o        (data_o),
    .resp_o        (resp_o),
    .write_fault_o (write_fault_o),
    .read_fault_o  (read_fault_o),
    .timeout_o     (timeout_o),
    .done_o        (done_o),
    .AW_READY      (AW_READY),
    .AW_VALID      (AW_VALID),
    .AW_ADDR       (AW_ADDR),
    .AW_PROT       (AW_PROT),
    .W_READY       (W_READY),
    .W_VALID       (W_VALID),
    .W_DATA        (W_DATA),
    .W_STRB        (W_STRB),
    .B_RESP        (B_RESP),
    .B_VALID       (B_VALID),
    .B_READY       (B_READY),
    .AR_READY      (AR_READY),
    .AR_VALID      (AR_VALID),
    .AR_ADDR       (AR_ADDR),
    .AR_PROT       (AR_PROT),
    .R_DATA        (R_DATA),
    .R_RESP        (R_RESP),
    .R_VALID       (R_VALID),
    .R_READY       (R_READY)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Bus monitor, sampled mid-cycle so it sees the values present at the next edge.
  int unsigned     done_cnt;
  int unsigned     aw_hs;
  int unsigned     w_hs;
  logic [7:0]      order_log;
  logic [AW_W-1:0] last_aw_addr;
  logic [AW_W-1:0] last_ar_addr;
  logic [DW-1:0]   last_w_data;
  logic [SW-1:0]   last_w_strb;

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (AW_VALID && AW_READY) begin
      aw_hs++;
      last_aw_addr = AW_ADDR;
      order_log = {order_log[6:0], 1'b1};
    end
    if (W_VALID && W_READY) begin
      w_hs++;
      last_w_data = W_DATA;
      last_w_strb = W_STRB;
    end
    if (AR_VALID && AR_READY) begin
      last_ar_addr = AR_ADDR;
      order_log = {order_log[6:0], 1'b0};
    end
  end

  int unsigned n_checks;
  int unsigned n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic slave_idle();
    AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0; B_RESP = 2'b00;
    AR_READY = 1'b0; R_VALID = 1'b0; R_RESP = 2'b00; R_DATA = '0;
  endtask

  task automatic slave_auto(input logic [DW-1:0] rdata);
    AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; B_RESP = 2'b00;
    AR_READY = 1'b1; R_VALID = 1'b1; R_RESP = 2'b00; R_DATA = rdata;
  endtask

  task automatic wait_done(input string tag);
    int unsigned i = 0;
    while (!done_o && i < 40) begin
      step();
      i++;
    end
    check(tag, done_o, 1);
  endtask

  // Steps until n completions are seen; counts cycles where ready_o was high in between.
  task automatic run_dones(input int unsigned n, output int unsigned ready_hi);
    int unsigned seen = 0;
    ready_hi = 0;
    for (int i = 0; i < 60 && seen < n; i++) begin
      step();
      if (done_o) seen++;
      else if (ready_o) ready_hi++;
    end
    check("dones_reached", seen, n);
  endtask

  // Counts cycles the launch VALID stays high, starting from the cycle after launch.
  task automatic hold_cycles(input bit is_wr, output int unsigned cnt);
    cnt = (is_wr ? AW_VALID : AR_VALID) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (is_wr ? AW_VALID : AR_VALID) cnt++;
      else break;
    end
  endtask

  initial begin
    int unsigned base, base_aw, base_w, hi, cnt;
    n_checks = 0;
    n_fail   = 0;
    rstn_i = 1'b0;
    start_write_i = 1'b0; start_read_i = 1'b0;
    waddr_i = '0; wdata_i = '0; wstrb_i = '0; raddr_i = '0;
    slave_idle();
    step(); step();

    check("rst_ready", ready_o, 1);
    check("rst_valids", {AW_VALID, W_VALID, AR_VALID, B_READY, R_READY}, 0);
    check("rst_data", data_o, 0);
    check("rst_resp", resp_o, 0);
    check("rst_flags", {done_o, write_fault_o, read_fault_o, timeout_o}, 0);
    check("prot", {AW_PROT, AR_PROT}, 0);
    rstn_i = 1'b1;
    step();

    // Write, W accepted two cycles ahead of AW
    base = done_cnt; base_aw = aw_hs; base_w = w_hs;
    waddr_i = 64'h1000; wdata_i = 32'hDEADBEEF; wstrb_i = 4'b0011; start_write_i = 1'b1;
    step();
    start_write_i = 1'b0; waddr_i = 64'hFFFF; wdata_i = '0; wstrb_i = '1;
    check("wr_launch", {AW_VALID, W_VALID, ready_o}, 3'b110);
    check("wr_aw_addr", AW_ADDR, 64'h1000);
    check("wr_w_data", W_DATA, 32'hDEADBEEF);
    check("wr_w_strb", W_STRB, 4'b0011);
    W_READY = 1'b1;
    step();
    W_READY = 1'b0;
    check("wr_w_first", {AW_VALID, W_VALID, B_READY}, 3'b100);
    step();
    check("wr_aw_held", AW_ADDR, 64'h1000);
    AW_READY = 1'b1;
    step();
    AW_READY = 1'b0;
    check("wr_b_phase", {AW_VALID, W_VALID, B_READY}, 3'b001);
    B_VALID = 1'b1; B_RESP = 2'b00;
    step();
    B_VALID = 1'b0;
    check("wr_done", {done_o, write_fault_o, read_fault_o, timeout_o}, 4'b1000);
    check("wr_resp", resp_o, 2'b00);
    step();
    check("wr_idle", {ready_o, done_o}, 2'b10);
    check("wr_aw_hs", aw_hs - base_aw, 1);
    check("wr_w_hs", w_hs - base_w, 1);
    check("wr_done_cnt", done_cnt - base, 1);

    // Read with SLVERR
    raddr_i = 64'h2000; start_read_i = 1'b1;
    step();
    start_read_i = 1'b0; raddr_i = '0;
    check("rd_launch", {AR_VALID, ready_o}, 2'b10);
    check("rd_ar_addr", AR_ADDR, 64'h2000);
    AR_READY = 1'b1;
    step();
    AR_READY = 1'b0;
    check("rd_r_phase", {AR_VALID, R_READY}, 2'b01);
    R_VALID = 1'b1; R_DATA = 32'h12345678; R_RESP = 2'b10;
    step();
    slave_idle();
    check("rd_done", {done_o, read_fault_o, write_fault_o, timeout_o}, 4'b1100);
    check("rd_data", data_o, 32'h12345678);
    check("rd_resp", resp_o, 2'b10);
    step();
    check("rd_idle", {ready_o, read_fault_o}, 2'b10);

    // Two back-to-back conflicts: W then pending R, then R then pending W
    slave_auto(32'hCAFEF00D);
    base = done_cnt;
    waddr_i = 64'h3000; wdata_i = 32'h11111111; wstrb_i = 4'hF; raddr_i = 64'h4000;
    start_write_i = 1'b1; start_read_i = 1'b1;
    step();
    start_write_i = 1'b0; start_read_i = 1'b0;
    waddr_i = 64'hDEAD; raddr_i = 64'hBEEF; wdata_i = '0; wstrb_i = '0;
    check("arb1_winner", {AW_VALID, AR_VALID, ready_o}, 3'b100);
    run_dones(2, hi);
    check("arb1_ready_low", hi, 0);
    check("arb1_pend_raddr", last_ar_addr, 64'h4000);
    step();
    check("arb1_idle", ready_o, 1);
    waddr_i = 64'h5000; wdata_i = 32'h22222222; wstrb_i = 4'hC; raddr_i = 64'h6000;
    start_write_i = 1'b1; start_read_i = 1'b1;
    step();
    start_write_i = 1'b0; start_read_i = 1'b0;
    waddr_i = 64'hDEAD; raddr_i = 64'hBEEF; wdata_i = '0; wstrb_i = '0;
    check("arb2_winner", {AW_VALID, AR_VALID, ready_o}, 3'b010);
    check("arb2_ar_addr", AR_ADDR, 64'h6000);
    run_dones(2, hi);
    check("arb2_ready_low", hi, 0);
    step(); step();
    check("arb_done_cnt", done_cnt - base, 4);
    check("arb_order", order_log[3:0], 4'b1001);
    check("arb_pend_waddr", last_aw_addr, 64'h5000);
    check("arb_pend_wdata", last_w_data, 32'h22222222);
    check("arb_pend_wstrb", last_w_strb, 4'hC);
    check("arb_rdata", data_o, 32'hCAFEF00D);

    // Read watchdog abort with AR_READY stuck low
    slave_idle();
    raddr_i = 64'h7000; start_read_i = 1'b1;
    step();
    start_read_i = 1'b0;
    hold_cycles(1'b0, cnt);
    check("to_rd_cycles", cnt, 16);
    check("to_rd_flags", {done_o, timeout_o, read_fault_o, write_fault_o}, 4'b1110);
    check("to_rd_resp", resp_o, 2'b10);
    check("to_rd_data_kept", data_o, 32'hCAFEF00D);
    step();
    check("to_rd_idle", {ready_o, done_o, timeout_o}, 3'b100);

    // Conflict whose write winner times out; pending read still launches
    waddr_i = 64'h8000; wdata_i = 32'h33333333; wstrb_i = 4'hF; raddr_i = 64'h9000;
    start_write_i = 1'b1; start_read_i = 1'b1;
    step();
    start_write_i = 1'b0; start_read_i = 1'b0; raddr_i = '0;
    check("to_wr_winner", {AW_VALID, AR_VALID}, 2'b10);
    hold_cycles(1'b1, cnt);
    check("to_wr_cycles", cnt, 16);
    check("to_wr_flags", {done_o, timeout_o, write_fault_o, read_fault_o}, 4'b1110);
    slave_auto(32'h55AA55AA);
    step();
    check("to_pend_launch", {AR_VALID, ready_o}, 2'b10);
    check("to_pend_addr", AR_ADDR, 64'h9000);
    wait_done("to_pend_done");
    check("to_pend_flags", {timeout_o, read_fault_o, write_fault_o}, 3'b000);
    check("to_pend_data", data_o, 32'h55AA55AA);
    step();

    // B_VALID on the exact expiry cycle: normal completion (EXOKAY is a fault)
    slave_idle();
    AW_READY = 1'b1; W_READY = 1'b1;
    waddr_i = 64'hA000; wdata_i = 32'h44444444; wstrb_i = 4'h1; start_write_i = 1'b1;
    step();
    start_write_i = 1'b0;
    step();
    check("bx_b_phase", B_READY, 1);
    AW_READY = 1'b0; W_READY = 1'b0;
    repeat (14) step();
    check("bx_pre", {B_READY, done_o}, 2'b10);
    B_VALID = 1'b1; B_RESP = 2'b01;
    step();
    B_VALID = 1'b0; B_RESP = 2'b00;
    check("bx_done", {done_o, timeout_o, write_fault_o, read_fault_o}, 4'b1010);
    check("bx_resp", resp_o, 2'b01);
    step();
    check("bx_idle", ready_o, 1);

    // Reset while waiting for B, then a fresh read
    AW_READY = 1'b1; W_READY = 1'b1;
    waddr_i = 64'hB000; wdata_i = 32'h0F0F0F0F; wstrb_i = 4'hF; start_write_i = 1'b1;
    step();
    start_write_i = 1'b0;
    step();
    check("mr_b_phase", B_READY, 1);
    slave_idle();
    rstn_i = 1'b0;
    base = done_cnt;
    step();
    rstn_i = 1'b1;
    check("mr_ready", ready_o, 1);
    check("mr_valids", {AW_VALID, W_VALID, AR_VALID, B_READY, R_READY}, 0);
    check("mr_data", data_o, 0);
    check("mr_resp", resp_o, 0);
    check("mr_flags", {done_o, write_fault_o, read_fault_o, timeout_o}, 0);
    step(); step();
    check("mr_no_done", done_cnt - base, 0);
    slave_auto(32'h0BADF00D);
    raddr_i = 64'hC000; start_read_i = 1'b1;
    step();
    start_read_i = 1'b0;
    check("mr_rd_addr", AR_ADDR, 64'hC000);
    wait_done("mr_rd_done");
    check("mr_rd_data", data_o, 32'h0BADF00D);
    check("mr_rd_flags", {resp_o, read_fault_o, timeout_o}, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
